// File: rtl/alu_iter_exec_if.sv
// Request/response bundle between the ID/EX stage and the iterative execution unit.
// master drives requests and accepts results; slave is the execution unit.
interface alu_iter_exec_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [3:0]            Operation;
    logic [DATA_WIDTH-1:0] SrcA;
    logic [DATA_WIDTH-1:0] SrcB;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  Zero;
    logic                  Illegal;

    modport master (
        output in_valid, Operation, SrcA, SrcB, out_ready,
        input  in_ready, out_valid, ALUResult, Zero, Illegal
    );

    modport slave (
        input  in_valid, Operation, SrcA, SrcB, out_ready,
        output in_ready, out_valid, ALUResult, Zero, Illegal
    );
endinterface

// File: rtl/alu_iter_exec.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops, shifts walked SHIFT_STEP bits per cycle.
// Result is held in DONE until the consumer takes it; a new request may overlap that hand-off.
module alu_iter_exec #(
    parameter int DATA_WIDTH = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_iter_exec_if.slave     bus
);
    localparam int DW  = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);
    localparam logic [SHW:0] STEP_C = (SHW+1)'(SHIFT_STEP);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   result_q, result_d;
    logic            zero_q, zero_d;
    logic            illegal_q, illegal_d;
    logic [DW-1:0]   sh_val_q, sh_val_d;
    logic [1:0]      sh_op_q, sh_op_d;
    logic [SHW-1:0]  sh_rem_q, sh_rem_d;

    logic            in_ready_w;
    logic            xfer;
    logic            is_shift;
    logic            start_shift;
    logic [SHW-1:0]  shamt;
    logic [DW-1:0]   calc_res;
    logic            calc_zero;
    logic            calc_ill;
    logic [SHW:0]    step;
    logic [DW-1:0]   stepped;
    logic [SHW-1:0]  rem_left;

    assign shamt       = bus.SrcB[SHW-1:0];
    assign is_shift    = (bus.Operation == 4'b0100) || (bus.Operation == 4'b0101) ||
                         (bus.Operation == 4'b0111);
    assign xfer        = bus.in_valid && in_ready_w;
    assign start_shift = is_shift && (shamt != '0);

    // Single-cycle result; shift ops only land here when shamt is zero, so they pass A through.
    always_comb begin
        calc_res  = '0;
        calc_zero = 1'b0;
        calc_ill  = 1'b0;
        case (bus.Operation)
            4'b0000: calc_res = bus.SrcA & bus.SrcB;
            4'b0001: calc_res = bus.SrcA | bus.SrcB;
            4'b0010: calc_res = bus.SrcA + bus.SrcB;
            4'b0011: calc_res = bus.SrcA ^ bus.SrcB;
            4'b0100: calc_res = bus.SrcA;
            4'b0101: calc_res = bus.SrcA;
            4'b0110: calc_res = bus.SrcA - bus.SrcB;
            4'b0111: calc_res = bus.SrcA;
            4'b1000: calc_zero = (bus.SrcA == bus.SrcB);
            4'b1001: calc_zero = (bus.SrcA != bus.SrcB);
            4'b1010: calc_zero = ($signed(bus.SrcA) >= $signed(bus.SrcB));
            4'b1011: calc_zero = ($signed(bus.SrcA) <  $signed(bus.SrcB));
            4'b1100: calc_res = {{(DW-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
            4'b1101: calc_res = bus.SrcA + bus.SrcB;
            4'b1110: calc_res = {{(DW-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
            default: calc_ill = 1'b1;
        endcase
        if (bus.Operation[3:2] != 2'b10 && !calc_ill) begin
            calc_zero = (calc_res == '0);
        end
    end

    // One shift iteration: min(SHIFT_STEP, remaining); SRA keeps replicating the original sign bit.
    always_comb begin
        step = ({1'b0, sh_rem_q} < STEP_C) ? {1'b0, sh_rem_q} : STEP_C;
        case (sh_op_q)
            2'b01:   stepped = sh_val_q >> step;
            2'b11:   stepped = $signed(sh_val_q) >>> step;
            default: stepped = sh_val_q << step;
        endcase
        rem_left = sh_rem_q - step[SHW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (xfer) state_d = start_shift ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                if (rem_left == '0) state_d = S_DONE;
            end
            S_DONE: begin
                if (xfer)               state_d = start_shift ? S_SHIFT : S_DONE;
                else if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_w    = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
        bus.in_ready  = in_ready_w;
        bus.out_valid = (state_q == S_DONE);
        bus.ALUResult = result_q;
        bus.Zero      = zero_q;
        bus.Illegal   = illegal_q;
    end

    always_comb begin
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        sh_val_d  = sh_val_q;
        sh_op_d   = sh_op_q;
        sh_rem_d  = sh_rem_q;
        if (xfer) begin
            if (start_shift) begin
                sh_val_d = bus.SrcA;
                sh_op_d  = bus.Operation[1:0];
                sh_rem_d = shamt;
            end else begin
                result_d  = calc_res;
                zero_d    = calc_zero;
                illegal_d = calc_ill;
            end
        end else if (state_q == S_SHIFT) begin
            sh_val_d = stepped;
            sh_rem_d = rem_left;
            if (rem_left == '0) begin
                result_d  = stepped;
                zero_d    = (stepped == '0);
                illegal_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
            sh_val_q  <= '0;
            sh_op_q   <= '0;
            sh_rem_q  <= '0;
        end else begin
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
            sh_val_q  <= sh_val_d;
            sh_op_q   <= sh_op_d;
            sh_rem_q  <= sh_rem_d;
        end
    end
endmodule

// File: tb/tb_alu_iter_exec.sv
// Drives two units (SHIFT_STEP 1 and 3) with identical requests and compares each
// against an arithmetic reference model, including per-op latency.
module tb_alu_iter_exec;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   chk_cnt  = 0;
    int   pass_cnt = 0;

    always #5 clk = ~clk;

    alu_iter_exec_if #(.DATA_WIDTH(DW)) bus_a ();
    alu_iter_exec_if #(.DATA_WIDTH(DW)) bus_b ();

    alu_iter_exec #(.DATA_WIDTH(DW), .SHIFT_STEP(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    alu_iter_exec #(.DATA_WIDTH(DW), .SHIFT_STEP(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else             pass_cnt++;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus_a.in_valid = v;  bus_b.in_valid = v;
        bus_a.Operation = op; bus_b.Operation = op;
        bus_a.SrcA = a;      bus_b.SrcA = a;
        bus_a.SrcB = b;      bus_b.SrcB = b;
    endtask

    task automatic set_rdy(input logic r);
        bus_a.out_ready = r;
        bus_b.out_ready = r;
    endtask

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic z, output logic ill);
        int sh;
        sh  = int'(b[4:0]);
        r   = '0;
        z   = 1'b0;
        ill = 1'b0;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd2:  r = a + b;
            4'd3:  r = a ^ b;
            4'd4:  r = a << sh;
            4'd5:  r = a >> sh;
            4'd6:  r = a - b;
            4'd7:  r = $signed(a) >>> sh;
            4'd8:  z = (a == b);
            4'd9:  z = (a != b);
            4'd10: z = ($signed(a) >= $signed(b));
            4'd11: z = ($signed(a) <  $signed(b));
            4'd12: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd13: r = a + b;
            4'd14: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: ill = 1'b1;
        endcase
        if (op < 4'd8 || (op >= 4'd12 && op != 4'd15)) z = (r == 32'd0);
    endfunction

    function automatic int exp_lat(input logic [3:0] op, input logic [31:0] b, input int step);
        int sh;
        sh = int'(b[4:0]);
        if ((op == 4'd4 || op == 4'd5 || op == 4'd7) && sh != 0) return 1 + (sh + step - 1) / step;
        return 1;
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] er, ra, rb;
        logic        ez, ei, za, zb, ia, ib;
        int          la, lb, n;
        bit          got_a, got_b, busy_ok;
        model(op, a, b, er, ez, ei);
        ra = 'x; rb = 'x; za = 'x; zb = 'x; ia = 'x; ib = 'x;
        la = -1; lb = -1; n = 0;
        got_a = 0; got_b = 0; busy_ok = 1;
        @(negedge clk);
        drive(1'b1, op, a, b);
        set_rdy(1'b1);
        check({tag, ".in_ready"}, {bus_a.in_ready, bus_b.in_ready}, 2'b11);
        while (!(got_a && got_b) && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) drive(1'b0, 4'($urandom), $urandom, $urandom);
            if (!got_a) begin
                if (bus_a.out_valid) begin
                    got_a = 1; la = n; ra = bus_a.ALUResult; za = bus_a.Zero; ia = bus_a.Illegal;
                end else if (bus_a.in_ready) busy_ok = 0;
            end
            if (!got_b) begin
                if (bus_b.out_valid) begin
                    got_b = 1; lb = n; rb = bus_b.ALUResult; zb = bus_b.Zero; ib = bus_b.Illegal;
                end else if (bus_b.in_ready) busy_ok = 0;
            end
        end
        check({tag, ".done"}, {got_a, got_b}, 2'b11);
        check({tag, ".busy"}, busy_ok, 1'b1);
        check({tag, ".lat1"}, la, exp_lat(op, b, 1));
        check({tag, ".lat3"}, lb, exp_lat(op, b, 3));
        check({tag, ".res1"}, {ia, za, ra}, {ei, ez, er});
        check({tag, ".res3"}, {ib, zb, rb}, {ei, ez, er});
        $display("op=%h a=%h b=%h -> res=%h zero=%b ill=%b lat1=%0d lat3=%0d (%s)",
                 op, a, b, ra, za, ia, la, lb, tag);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] a, b;

        rst_n = 1'b0;
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        set_rdy(1'b0);
        repeat (3) @(negedge clk);
        check("rst.out_valid", {bus_a.out_valid, bus_b.out_valid}, 2'b00);
        check("rst.result", bus_a.ALUResult, 32'd0);
        check("rst.flags", {bus_a.Zero, bus_a.Illegal, bus_b.Zero, bus_b.Illegal}, 4'b0000);
        check("rst.in_ready", {bus_a.in_ready, bus_b.in_ready}, 2'b11);
        rst_n = 1'b1;

        run_op(4'b0010, 32'h7FFF_FFFF, 32'd1,  "add_ovf");
        run_op(4'b0110, 32'd5,         32'd5,  "sub_zero");
        run_op(4'b1011, 32'hFFFF_FFFF, 32'd1,  "blt");
        run_op(4'b1010, 32'hFFFF_FFFF, 32'd1,  "bge");
        run_op(4'b0111, 32'h8000_0000, 32'd31, "sra31");
        run_op(4'b0100, 32'd1,         32'd0,  "sll0");
        run_op(4'b0101, 32'h0000_00F0, 32'd4,  "srl4");
        run_op(4'b1111, 32'h1234_5678, 32'd9,  "illegal");

        // Result held under back-pressure, then handed off alongside a new request.
        @(negedge clk);
        drive(1'b1, 4'b0011, 32'h0000_00FF, 32'h0000_000F);
        set_rdy(1'b0);
        @(negedge clk);
        drive(1'b0, 4'b0010, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            check("hold.valid", {bus_a.out_valid, bus_b.out_valid}, 2'b11);
            check("hold.res", bus_a.ALUResult, 32'h0000_00F0);
            @(negedge clk);
        end
        check("hold.blocked", {bus_a.in_ready, bus_b.in_ready}, 2'b00);
        drive(1'b1, 4'b0010, 32'd3, 32'd4);
        set_rdy(1'b1);
        #1;
        check("b2b.in_ready", {bus_a.in_ready, bus_b.in_ready}, 2'b11);
        @(negedge clk);
        drive(1'b0, 4'd0, 32'd0, 32'd0);
        check("b2b.valid", {bus_a.out_valid, bus_b.out_valid}, 2'b11);
        check("b2b.res", {bus_a.ALUResult, bus_b.ALUResult}, {32'd7, 32'd7});
        $display("hold/b2b: xor held, add result=%h", bus_a.ALUResult);
        @(negedge clk);
        check("b2b.drain", {bus_a.out_valid, bus_b.out_valid}, 2'b00);

        // Reset in the middle of a long shift.
        @(negedge clk);
        drive(1'b1, 4'b0111, 32'h8000_0000, 32'd31);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b0, 4'd0, 32'd0, 32'd0);
        end
        check("midrst.busy", {bus_a.in_ready, bus_b.in_ready}, 2'b00);
        rst_n = 1'b0;
        #1;
        check("midrst.valid", {bus_a.out_valid, bus_b.out_valid}, 2'b00);
        check("midrst.result", {bus_a.ALUResult, bus_b.ALUResult}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst.after", {bus_a.out_valid, bus_b.out_valid, bus_a.in_ready, bus_b.in_ready}, 4'b0011);
        end
        $display("mid-shift reset: outputs cleared, units idle");
        run_op(4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "illegal2");

        for (int t = 0; t < 40; t++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 3) == 0) b = a;
            run_op(op, a, b, "rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
